// File: rtl/downsampler2_pkg.sv
// Shared sampling constants and types for the 2x down/up-sampler pair.
// Pixel width, default frame geometry and the rounding box-average helper live here.
package downsampler2_pkg;

   localparam int PIX_W       = 8;
   localparam int DEF_FRAME_W = 800;
   localparam int DEF_FRAME_H = 600;
   localparam int CNT_W       = 10;
   localparam int OCNT_W      = 9;
   localparam int PAIR_W      = PIX_W + 1;
   localparam int SUM_W       = PIX_W + 2;

   // Upsampler side: it consumes the half-size frames this block produces.
   localparam int UP_FACTOR   = 2;
   localparam int UP_IN_W     = DEF_FRAME_W / UP_FACTOR;
   localparam int UP_IN_H     = DEF_FRAME_H / UP_FACTOR;

   // Position of an input pixel inside its 2x2 block: {row[0], col[0]}.
   typedef enum logic [1:0] {
      PH_TOP_LEFT  = 2'b00,
      PH_TOP_RIGHT = 2'b01,
      PH_BOT_LEFT  = 2'b10,
      PH_BOT_RIGHT = 2'b11
   } phase_e;

   typedef struct packed {
      logic [CNT_W-1:0] row;
      logic [CNT_W-1:0] col;
   } pos_t;

   typedef struct packed {
      logic [OCNT_W-1:0] row;
      logic [OCNT_W-1:0] col;
   } opos_t;

   // Round-half-up divide by four; 4*255+2 still fits SUM_W bits.
   function automatic logic [PIX_W-1:0] box_avg(input logic [SUM_W-1:0] sum);
      logic [SUM_W-1:0] r;
      r = sum + SUM_W'(2);
      return r[SUM_W-1:2];
   endfunction

endpackage

// File: rtl/downsampler2_pair_line_buffer.sv
// Half-row store of horizontal pair sums; synchronous read, 1-cycle latency, read data held until next read.
// No backpressure: one write and one read port, both always accepted.
module pair_line_buffer
   import downsampler2_pkg::*;
#(
   parameter int DEPTH = DEF_FRAME_W / 2,
   parameter int AW    = $clog2(DEPTH),
   parameter int DW    = PAIR_W
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_dat,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_dat
);

   // Contents are rewritten by every even row before use, so no reset.
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rd_dat_q, rd_dat_d;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_dat;
      end
   end

   always_comb begin
      rd_dat_d = rd_dat_q;
      if (rd_en) begin
         rd_dat_d = mem_q[rd_addr];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_dat_q <= '0;
      end else begin
         rd_dat_q <= rd_dat_d;
      end
   end

   assign rd_dat = rd_dat_q;

endmodule

// File: rtl/downsampler2.sv
// 2x2 box-average downsampler for raster luminance; one output per odd/odd input pixel, 1-cycle latency.
// No backpressure: input pixels are accepted whenever valid is high, gaps are allowed anywhere.
module downsampler2
   import downsampler2_pkg::*;
#(
   parameter int FRAME_W = DEF_FRAME_W,
   parameter int FRAME_H = DEF_FRAME_H
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              frame_start,
   input  logic              valid,
   input  logic [PIX_W-1:0]  data,
   output logic [PIX_W-1:0]  dataout,
   output logic              validout,
   output logic [CNT_W-1:0]  current_rowcount,
   output logic [CNT_W-1:0]  current_colcount,
   output logic [OCNT_W-1:0] out_rowcount,
   output logic [OCNT_W-1:0] out_colcount,
   output logic              frame_done
);

   localparam int               LB_DEPTH = FRAME_W / 2;
   localparam int               LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(FRAME_H - 1);

   pos_t              pos_q, pos_d, eff;
   opos_t             opos_q, opos_d;
   logic [PIX_W-1:0]  pair_q, pair_d;
   logic [PIX_W-1:0]  dataout_q, dataout_d;
   logic              validout_q, validout_d;
   logic              frame_done_q, frame_done_d;
   phase_e            phase;
   logic              lb_wr_en, lb_rd_en, emit;
   logic [LB_AW-1:0]  lb_addr;
   logic [PAIR_W-1:0] lb_wr_dat, lb_rd_dat;
   logic [SUM_W-1:0]  box_sum;

   always_comb begin
      // frame_start makes this cycle's pixel (if any) land at (0,0).
      eff       = frame_start ? '0 : pos_q;
      phase     = phase_e'({eff.row[0], eff.col[0]});
      lb_addr   = LB_AW'(eff.col >> 1);
      lb_wr_en  = valid && (phase == PH_TOP_RIGHT);
      lb_rd_en  = valid && (phase == PH_BOT_LEFT);
      emit      = valid && (phase == PH_BOT_RIGHT);
      lb_wr_dat = PAIR_W'(pair_q) + PAIR_W'(data);
      box_sum   = SUM_W'(lb_rd_dat) + SUM_W'(pair_q) + SUM_W'(data);

      pos_d = eff;
      if (valid) begin
         if (eff.col == COL_LAST) begin
            pos_d.col = '0;
            pos_d.row = (eff.row == ROW_LAST) ? '0 : eff.row + CNT_W'(1);
         end else begin
            pos_d.col = eff.col + CNT_W'(1);
         end
      end

      pair_d = pair_q;
      if (valid && !eff.col[0]) begin
         pair_d = data;
      end

      opos_d = opos_q;
      if (frame_start) begin
         opos_d = '0;
      end
      if (emit) begin
         opos_d.row = OCNT_W'(eff.row >> 1);
         opos_d.col = OCNT_W'(eff.col >> 1);
      end

      dataout_d    = emit ? box_avg(box_sum) : dataout_q;
      validout_d   = emit;
      frame_done_d = emit && (eff.row == ROW_LAST) && (eff.col == COL_LAST);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pos_q        <= '0;
         opos_q       <= '0;
         pair_q       <= '0;
         dataout_q    <= '0;
         validout_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         pos_q        <= pos_d;
         opos_q       <= opos_d;
         pair_q       <= pair_d;
         dataout_q    <= dataout_d;
         validout_q   <= validout_d;
         frame_done_q <= frame_done_d;
      end
   end

   pair_line_buffer #(
      .DEPTH (LB_DEPTH),
      .AW    (LB_AW),
      .DW    (PAIR_W)
   ) u_line_buf (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_en   (lb_wr_en),
      .wr_addr (lb_addr),
      .wr_dat  (lb_wr_dat),
      .rd_en   (lb_rd_en),
      .rd_addr (lb_addr),
      .rd_dat  (lb_rd_dat)
   );

   assign dataout          = dataout_q;
   assign validout         = validout_q;
   assign frame_done       = frame_done_q;
   assign current_rowcount = pos_q.row;
   assign current_colcount = pos_q.col;
   assign out_rowcount     = opos_q.row;
   assign out_colcount     = opos_q.col;

endmodule

// File: tb/tb_downsampler2.sv
// Bench for downsampler2 on a reduced 32x16 frame: block vectors, whole frames vs. an image model.
module tb_downsampler2;
   import downsampler2_pkg::*;

   localparam int W  = 32;
   localparam int H  = 16;
   localparam int OW = W / 2;
   localparam int OH = H / 2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        frame_start = 1'b0;
   logic        valid = 1'b0;
   logic [7:0]  data = 8'd0;
   logic [7:0]  dataout;
   logic        validout;
   logic [9:0]  current_rowcount, current_colcount;
   logic [8:0]  out_rowcount, out_colcount;
   logic        frame_done;

   downsampler2 #(.FRAME_W(W), .FRAME_H(H)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .frame_start      (frame_start),
      .valid            (valid),
      .data             (data),
      .dataout          (dataout),
      .validout         (validout),
      .current_rowcount (current_rowcount),
      .current_colcount (current_colcount),
      .out_rowcount     (out_rowcount),
      .out_colcount     (out_colcount),
      .frame_done       (frame_done)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] pix;
      logic [8:0] row;
      logic [8:0] col;
      logic       done;
   } outrec_t;

   typedef struct packed {
      logic [7:0] p0;
      logic [7:0] p1;
      logic [7:0] p2;
      logic [7:0] p3;
      logic [7:0] expv;
   } vec_t;

   outrec_t    got_q[$];
   outrec_t    exp_q[$];
   int         fd_cnt = 0;
   int         stray_cnt = 0;
   int         n_checks = 0;
   int         n_pass = 0;
   logic [7:0] img [H][W];
   vec_t       vecs [8];

   always @(negedge clock) begin
      if (validout) got_q.push_back('{dataout, out_rowcount, out_colcount, frame_done});
      if (frame_done) fd_cnt++;
      if (frame_done && !validout) stray_cnt++;
   end

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
   endtask

   task automatic put(input logic [7:0] d, input int gap, input bit fs);
      while (int'($urandom_range(0, 99)) < gap) @(negedge clock);
      valid = 1'b1;
      data = d;
      frame_start = fs;
      @(negedge clock);
      valid = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic fill(input bit rnd);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = rnd ? 8'($urandom_range(0, 255)) : 8'd100;
   endtask

   // Model: rounded mean of the four source pixels of output (r,c).
   function automatic logic [7:0] ref_box(input int r, input int c);
      int s;
      s = int'(img[2*r][2*c]) + int'(img[2*r][2*c+1]) + int'(img[2*r+1][2*c]) + int'(img[2*r+1][2*c+1]);
      return 8'((s + 2) / 4);
   endfunction

   // Expected outputs for the blocks whose last pixel lies among the first npix raster pixels.
   task automatic build_exp(input int npix);
      outrec_t rec;
      exp_q.delete();
      for (int r = 0; r < OH; r++)
         for (int c = 0; c < OW; c++)
            if ((2*r+1)*W + 2*c+1 < npix) begin
               rec.pix  = ref_box(r, c);
               rec.row  = 9'(r);
               rec.col  = 9'(c);
               rec.done = (r == OH-1) && (c == OW-1);
               exp_q.push_back(rec);
            end
   endtask

   task automatic feed(input int npix, input int gap, input bit fs_first);
      for (int i = 0; i < npix; i++) put(img[i / W][i % W], gap, fs_first && (i == 0));
   endtask

   task automatic run_cmp(input string tag, input int npix, input int gap, input bit fs_first);
      int base;
      int fd0;
      base = got_q.size();
      fd0 = fd_cnt;
      build_exp(npix);
      feed(npix, gap, fs_first);
      repeat (3) @(negedge clock);
      check({tag, " count"}, got_q.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++)
         check($sformatf("%s[%0d]", tag, i), int'(got_q[base + i]), int'(exp_q[i]));
      check({tag, " frame_done"}, fd_cnt - fd0, (npix == W*H) ? 1 : 0);
   endtask

   initial begin
      vecs[0] = '{8'd10,  8'd11,  8'd12,  8'd14,  8'd12};
      vecs[1] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
      vecs[2] = '{8'd0,   8'd0,   8'd0,   8'd2,   8'd1};
      vecs[3] = '{8'd0,   8'd0,   8'd0,   8'd1,   8'd0};
      vecs[4] = '{8'd1,   8'd1,   8'd1,   8'd0,   8'd1};
      vecs[5] = '{8'd2,   8'd0,   8'd0,   8'd0,   8'd1};
      vecs[6] = '{8'd128, 8'd127, 8'd1,   8'd0,   8'd64};
      vecs[7] = '{8'd200, 8'd201, 8'd202, 8'd202, 8'd201};

      // Inputs toggling while reset is held must not disturb anything.
      valid = 1'b1;
      data = 8'hAB;
      repeat (3) @(negedge clock);
      check("rst rowcount", int'(current_rowcount), 0);
      check("rst colcount", int'(current_colcount), 0);
      check("rst out_rowcount", int'(out_rowcount), 0);
      check("rst out_colcount", int'(out_colcount), 0);
      check("rst dataout", int'(dataout), 0);
      check("rst validout", int'(validout), 0);
      check("rst frame_done", int'(frame_done), 0);
      valid = 1'b0;
      reset_n = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin
            frame_start = 1'b1;
            @(negedge clock);
            frame_start = 1'b0;
            check($sformatf("vec%0d fs row", i), int'(current_rowcount), 0);
            check($sformatf("vec%0d fs col", i), int'(current_colcount), 0);
         end
         put(vecs[i].p0, 0, i % 2 == 1);
         put(vecs[i].p1, 0, 1'b0);
         for (int c = 2; c < W; c++) put(8'd0, 0, 1'b0);
         put(vecs[i].p2, 0, 1'b0);
         check($sformatf("vec%0d early validout", i), int'(validout), 0);
         put(vecs[i].p3, 0, 1'b0);
         check($sformatf("vec%0d validout", i), int'(validout), 1);
         check($sformatf("vec%0d dataout", i), int'(dataout), int'(vecs[i].expv));
         check($sformatf("vec%0d out pos", i), int'({out_rowcount, out_colcount}), 0);
         check($sformatf("vec%0d in pos", i), int'({current_rowcount, current_colcount}), (1 << 10) + 2);
         @(negedge clock);
         check($sformatf("vec%0d validout drop", i), int'(validout), 0);
      end

      fill(1'b0);
      run_cmp("const100", W*H, 0, 1'b1);
      check("wrap rowcount", int'(current_rowcount), 0);
      check("wrap colcount", int'(current_colcount), 0);

      fill(1'b1);
      run_cmp("rand_nogap", W*H, 0, 1'b0);
      run_cmp("rand_gap50", W*H, 50, 1'b0);

      fill(1'b1);
      run_cmp("broken", 11*W + 17, 30, 1'b0);
      check("brk rowcount", int'(current_rowcount), 11);
      check("brk colcount", int'(current_colcount), 17);
      frame_start = 1'b1;
      @(negedge clock);
      frame_start = 1'b0;
      check("brk fs rowcount", int'(current_rowcount), 0);
      check("brk fs colcount", int'(current_colcount), 0);
      check("brk fs validout", int'(validout), 0);
      fill(1'b1);
      run_cmp("after_break", W*H, 0, 1'b0);

      fill(1'b1);
      feed(5*W + 7, 0, 1'b0);
      put(img[5][7], 0, 1'b0);
      check("pre-reset validout", int'(validout), 1);
      #2 reset_n = 1'b0;
      #1;
      check("async rst validout", int'(validout), 0);
      check("async rst colcount", int'(current_colcount), 0);
      check("async rst rowcount", int'(current_rowcount), 0);
      check("async rst dataout", int'(dataout), 0);
      @(negedge clock);
      reset_n = 1'b1;
      fill(1'b1);
      run_cmp("after_reset", W*H, 20, 1'b0);

      check("stray frame_done", stray_cnt, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/downsampler2.md
DOWNSAMPLER2 -- requirements
Module: downsampler2

Interface
REQ-001 SHALL have parameter: FRAME_W, default 800, input pixels per row (even).
REQ-002 SHALL have parameter: FRAME_H, default 600, input rows per frame (even).
REQ-003 SHALL have port: clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: frame_start  input  1  one-cycle pulse; resynchronises counters to pixel (0,0).
REQ-006 SHALL have port: valid  input  1  data carries one raster-order input pixel this cycle.
REQ-007 SHALL have port: data  input  8  input luminance pixel.
REQ-008 SHALL have port: dataout  output  8  2x2 box-averaged output pixel.
REQ-009 SHALL have port: validout  output  1  dataout valid this cycle.
REQ-010 SHALL have port: current_rowcount  output  10  input row of the next expected pixel.
REQ-011 SHALL have port: current_colcount  output  10  input column of the next expected pixel.
REQ-012 SHALL have port: out_rowcount  output  9  output row of the pixel on dataout (0..FRAME_H/2-1).
REQ-013 SHALL have port: out_colcount  output  9  output column of the pixel on dataout (0..FRAME_W/2-1).
REQ-014 SHALL have port: frame_done  output  1  one-cycle pulse together with the last output pixel of a frame.

Function
REQ-015 SHALL advance colcount only on valid; wrap FRAME_W-1 -> 0 and increment rowcount on that wrap; wrap rowcount FRAME_H-1 -> 0.
REQ-016 SHALL, when valid arrives at an even column, latch data into a 8-bit pair register.
REQ-017 SHALL, when valid arrives at an odd column on an even row, write the 9-bit sum (pair register + data) to line-buffer address colcount>>1.
REQ-018 SHALL, when valid arrives at an even column on an odd row, issue a line-buffer read at address colcount>>1.
REQ-019 SHALL, when valid arrives at an odd column on an odd row, form a 10-bit sum = line-buffer read data + pair register + data, and output (sum + 2) >> 2.
REQ-020 SHALL register dataout/validout: validout high exactly one cycle after the qualifying valid of REQ-019, low otherwise; latency 1 cycle.
REQ-021 SHALL produce exactly FRAME_W/2 * FRAME_H/2 output pixels per complete frame, in raster order.
REQ-022 SHALL update out_colcount/out_rowcount with each output pixel, wrapping like REQ-015 at FRAME_W/2 and FRAME_H/2.
REQ-023 SHALL assert frame_done with the output pixel at (FRAME_H/2-1, FRAME_W/2-1).
REQ-024 SHALL tolerate arbitrary gaps in valid; line-buffer read data and the pair register SHALL hold until consumed.
REQ-025 SHALL, on frame_start, force input and output counters to 0 that cycle; a valid coincident with frame_start SHALL be treated as pixel (0,0).
REQ-026 SHALL discard a partially accumulated 2x2 block when frame_start interrupts a frame; no output is emitted for it.
REQ-027 SHALL not saturate: the maximum sum 4*255+2 = 1022 fits 10 bits; the result is always 0..255.

Reset
REQ-028 SHALL, while reset_n is low, hold colcount, rowcount, out counters, pair register, dataout at 0 and validout, frame_done at 0.
REQ-029 SHALL not require line-buffer contents to be reset; the first even row of each frame overwrites them.
REQ-030 SHALL, on reset release mid-frame, restart at pixel (0,0) with no spurious validout.

Structure
REQ-031 SHALL place FRAME_W, FRAME_H defaults and the pixel width (8) in the shared sampling package, together with the upsampler constants.
REQ-032 SHALL implement the line buffer as sub-module pair_line_buffer: FRAME_W/2 x 9-bit, one write port, one synchronous read port with 1-cycle latency and output hold.

Verification
REQ-033 SHALL check a constant-100 frame: 120000 outputs all 100, exactly one frame_done on the last output.
REQ-034 SHALL check the block at rows 0-1, cols 0-1 with pixels 10, 11, 12, 14: first output 12 ((47+2)>>2), at out (0,0).
REQ-035 SHALL check rounding and extremes: block 255x4 -> 255; block 0, 0, 0, 2 -> 1; block 0, 0, 0, 1 -> 0.
REQ-036 SHALL check random valid gaps (about 50 % duty) against a reference model: identical output sequence to the gap-free run.
REQ-037 SHALL check frame_start at input (301, 417): counters return to 0, no output for the broken block, next frame is correct.
REQ-038 SHALL check asserting reset_n low asynchronously mid-row: validout drops immediately, and the next frame matches the model.
